// File: rtl/rf_pkg.sv
// Shared types for the register-file bulk reader.
package rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } rf_rd_state_e;

  localparam int unsigned RF_DATA_W = 32;

endpackage

// File: rtl/reg_file_reader.sv
// Bulk-read engine: walks a contiguous (wrapping) RF range through the async read port
// and returns each word on a valid/ready stream with a last flag.
module reg_file_reader
  import rf_pkg::*;
#(
  parameter int unsigned addr_width_p = 6,
  parameter int unsigned data_width_p = RF_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [addr_width_p-1:0] base_addr_i,
  input  logic [addr_width_p:0]   count_i,
  output logic [addr_width_p-1:0] rf_addr_o,
  input  logic [data_width_p-1:0] rf_data_i,
  output logic [data_width_p-1:0] data_o,
  output logic                    valid_o,
  output logic                    last_o,
  input  logic                    ready_i,
  output logic                    busy_o,
  output logic                    done_o
);

  rf_rd_state_e            state_q, state_d;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [addr_width_p:0]   rem_q, rem_d;
  logic [data_width_p-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;

  logic load;
  logic rem_is_one;

  assign rem_is_one = (rem_q == (addr_width_p + 1)'(1));
  // The output register refills whenever it is empty or being drained this cycle.
  assign load       = (state_q == RUN) && (!valid_q || ready_i);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d  = base_addr_i;
          rem_d   = count_i;
          state_d = (count_i == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (load) begin
          data_d  = rf_data_i;
          valid_d = 1'b1;
          last_d  = rem_is_one;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          if (rem_is_one) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign rf_addr_o = (state_q == RUN) ? addr_q : '0;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign last_o    = last_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == FIN);

endmodule

// File: tb/tb_reg_file_reader.sv
// Directed self-checking bench for reg_file_reader with a 64-entry RF model.
module tb_reg_file_reader;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic [DW-1:0] data;
  logic          valid;
  logic          last;
  logic          ready;
  logic          busy;
  logic          done;

  logic [DW-1:0] rf [64];

  int n_vec;
  int n_bad;

  assign rf_data = rf[rf_addr];

  reg_file_reader #(
    .addr_width_p(AW),
    .data_width_p(DW)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .base_addr_i(base_addr),
    .count_i    (count),
    .rf_addr_o  (rf_addr),
    .rf_data_i  (rf_data),
    .data_o     (data),
    .valid_o    (valid),
    .last_o     (last),
    .ready_i    (ready),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int b, input int c);
    base_addr = AW'(b);
    count     = (AW + 1)'(c);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Full-speed burst checked against the RF model.
  task automatic burst(input string tag, input int b, input int c);
    kick(b, c);
    for (int i = 0; i < c; i++) begin
      tick();
      chk({tag, ".valid"}, 32'(valid), 32'd1);
      chk({tag, ".data"}, data, rf[(b + i) % 64]);
      chk({tag, ".last"}, 32'(last), (i == c - 1) ? 32'd1 : 32'd0);
    end
    tick();
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".vfall"}, 32'(valid), 32'd0);
    tick();
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    ready     = 1'b0;
    base_addr = '0;
    count     = '0;
    for (int i = 0; i < 64; i++) rf[i] = 32'(i * 3);

    repeat (2) tick();
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.last", 32'(last), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.data", data, 32'd0);
    chk("rst.addr", 32'(rf_addr), 32'd0);
    reset = 1'b0;
    tick();

    // T1: base 4, count 3, ready high.
    ready = 1'b1;
    kick(4, 3);
    chk("t1.busy", 32'(busy), 32'd1);
    chk("t1.novalid", 32'(valid), 32'd0);
    chk("t1.addr", 32'(rf_addr), 32'd4);
    tick();
    chk("t1.d0", data, 32'd12);
    chk("t1.v0", 32'(valid), 32'd1);
    chk("t1.l0", 32'(last), 32'd0);
    tick();
    chk("t1.d1", data, 32'd15);
    chk("t1.l1", 32'(last), 32'd0);
    tick();
    chk("t1.d2", data, 32'd18);
    chk("t1.l2", 32'(last), 32'd1);
    tick();
    chk("t1.done", 32'(done), 32'd1);
    chk("t1.vfall", 32'(valid), 32'd0);
    tick();
    chk("t1.done_pulse", 32'(done), 32'd0);
    chk("t1.idle", 32'(busy), 32'd0);

    // T2: wrapping addresses 62, 63, 0, 1.
    kick(62, 4);
    chk("t2.a0", 32'(rf_addr), 32'd62);
    tick();
    chk("t2.d0", data, 32'd186);
    chk("t2.a1", 32'(rf_addr), 32'd63);
    tick();
    chk("t2.d1", data, 32'd189);
    chk("t2.a2", 32'(rf_addr), 32'd0);
    tick();
    chk("t2.d2", data, 32'd0);
    chk("t2.a3", 32'(rf_addr), 32'd1);
    tick();
    chk("t2.d3", data, 32'd3);
    chk("t2.l3", 32'(last), 32'd1);
    tick();
    chk("t2.done", 32'(done), 32'd1);
    tick();

    // T3: backpressure for 5 cycles after the first valid word.
    ready = 1'b0;
    kick(4, 3);
    tick();
    chk("t3.d0", data, 32'd12);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3.hold_d", data, 32'd12);
      chk("t3.hold_v", 32'(valid), 32'd1);
      chk("t3.hold_l", 32'(last), 32'd0);
    end
    ready = 1'b1;
    tick();
    chk("t3.d1", data, 32'd15);
    tick();
    chk("t3.d2", data, 32'd18);
    chk("t3.l2", 32'(last), 32'd1);
    tick();
    chk("t3.done", 32'(done), 32'd1);
    chk("t3.vfall", 32'(valid), 32'd0);
    tick();

    // Backpressure on the final word holds it in DRAIN.
    kick(10, 1);
    ready = 1'b0;
    tick();
    chk("dr.d0", data, 32'd30);
    repeat (3) tick();
    chk("dr.hold_d", data, 32'd30);
    chk("dr.hold_l", 32'(last), 32'd1);
    chk("dr.nodone", 32'(done), 32'd0);
    ready = 1'b1;
    tick();
    chk("dr.done", 32'(done), 32'd1);
    tick();

    // T4: zero-length request.
    kick(7, 0);
    chk("t4.busy", 32'(busy), 32'd1);
    chk("t4.done", 32'(done), 32'd1);
    chk("t4.novalid", 32'(valid), 32'd0);
    tick();
    chk("t4.idle", 32'(busy), 32'd0);
    chk("t4.done_pulse", 32'(done), 32'd0);
    chk("t4.novalid2", 32'(valid), 32'd0);

    // T5: start pulsed while busy is ignored.
    kick(4, 3);
    base_addr = '0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("t5.d0", data, 32'd12);
    tick();
    chk("t5.d1", data, 32'd15);
    tick();
    chk("t5.d2", data, 32'd18);
    tick();
    chk("t5.done", 32'(done), 32'd1);
    tick();
    chk("t5.idle", 32'(busy), 32'd0);
    chk("t5.novalid", 32'(valid), 32'd0);

    // T6: reset after the 2nd word of a 10-word burst.
    kick(0, 10);
    tick();
    chk("t6.d0", data, 32'd0);
    tick();
    chk("t6.d1", data, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6.valid", 32'(valid), 32'd0);
    chk("t6.busy", 32'(busy), 32'd0);
    chk("t6.data", data, 32'd0);
    chk("t6.addr", 32'(rf_addr), 32'd0);
    chk("t6.last", 32'(last), 32'd0);
    chk("t6.done", 32'(done), 32'd0);
    tick();
    chk("t6.nodone", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    chk("t6.nodone2", 32'(done), 32'd0);
    burst("t6.fresh", 0, 10);

    // Whole-file read, with RF contents changed beforehand.
    for (int i = 0; i < 64; i++) rf[i] = 32'hA500_0000 | 32'(i * 7);
    burst("full", 17, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
